// File: rtl/sig_unsig_scan_display_pkg.sv
// Shared types and constants for the signed/unsigned scanned seven-segment display.
// Digit codes are 4 bits: 0-9 are BCD, the remaining codes select blank, dash and 'E'.
package sig_unsig_scan_display_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t DC_BLANK = 4'hA;
   localparam digit_t DC_DASH  = 4'hB;
   localparam digit_t DC_E     = 4'hC;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   typedef enum logic {IDLE, SHIFT} conv_state_t;

   // Double-dabble correction applied to each BCD digit before the shift
   function automatic digit_t bcd_adj(digit_t d);
      return (d >= 4'd5) ? digit_t'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/sig_unsig_scan_display_if.sv
// Operand/load handshake and multiplexed display outputs of the scan display.
interface sig_unsig_scan_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]  x;
   logic              interp;
   logic              ovf;
   logic              load;
   logic              busy;
   logic [DIGITS-1:0] anode;
   logic [6:0]        seg;

   modport master (output x, interp, ovf, load, input busy, anode, seg);
   modport slave  (input x, interp, ovf, load, output busy, anode, seg);
endinterface

// File: rtl/sig_unsig_scan_display_seg.sv
// Combinational digit-code to active-low seven-segment decoder.
module bcd_to_seven_seg
   import sig_unsig_scan_display_pkg::*;
(
   input  digit_t     i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         DC_DASH: o_seg = SEG_DASH;
         DC_E:    o_seg = SEG_E;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sig_unsig_scan_display.sv
// Signed/unsigned binary value to multiplexed decimal display: iterative double-dabble
// conversion into a display register, continuously scanned one digit at a time.
module sig_unsig_scan_display
   import sig_unsig_scan_display_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
)(
   input  logic                     clk,
   input  logic                     reset,
   sig_unsig_scan_display_if.slave  bus
);

   localparam int CNTW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
   localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW   = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
   localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(WIDTH - 1);
   localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]   IDX_LAST  = IW'(DIGITS - 1);

   conv_state_t             r_state, w_state_nxt;
   logic                    w_start, w_done;
   logic [CNTW-1:0]         r_cnt;
   logic [WIDTH-1:0]        r_mag, w_mag_in;
   logic                    w_neg_in, r_neg, r_ovf;
   logic [4*DIGITS-1:0]     r_bcd, w_bcd_adj, w_bcd_nxt;
   digit_t [DIGITS-1:0]     r_disp, w_codes;
   int                      w_msd;

   logic [SCW-1:0]          r_scan_cnt;
   logic [IW-1:0]           r_idx, w_idx_nxt;
   logic [DIGITS-1:0]       r_anode;
   logic [6:0]              r_seg, w_seg;

   // The most negative input negates to 2^(WIDTH-1), which still fits in WIDTH unsigned bits
   assign w_neg_in = bus.interp & bus.x[WIDTH-1];
   assign w_mag_in = w_neg_in ? (~bus.x + WIDTH'(1)) : bus.x;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.load) begin
               w_state_nxt = SHIFT;
               w_start     = 1'b1;
            end
         end
         SHIFT: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int d = 0; d < DIGITS; d++)
         w_bcd_adj[4*d +: 4] = bcd_adj(r_bcd[4*d +: 4]);
      w_bcd_nxt = (w_bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_mag[WIDTH-1]};
   end

   // Format the final BCD: blank leading zeros, dash left of the top digit, or a lone 'E'
   always_comb begin
      w_msd   = 0;
      w_codes = {DIGITS{DC_BLANK}};
      for (int d = 0; d < DIGITS; d++)
         if (w_bcd_nxt[4*d +: 4] != 4'd0) w_msd = d;
      for (int d = 0; d < DIGITS; d++) begin
         if (d <= w_msd)                  w_codes[d] = w_bcd_nxt[4*d +: 4];
         else if (r_neg && d == w_msd + 1) w_codes[d] = DC_DASH;
         else                             w_codes[d] = DC_BLANK;
      end
      if (r_ovf) begin
         w_codes    = {DIGITS{DC_BLANK}};
         w_codes[0] = DC_E;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_mag  <= '0;
         r_bcd  <= '0;
         r_neg  <= 1'b0;
         r_ovf  <= 1'b0;
         r_disp <= {DIGITS{DC_BLANK}};
      end else if (w_start) begin
         r_cnt <= '0;
         r_mag <= w_mag_in;
         r_bcd <= '0;
         r_neg <= w_neg_in;
         r_ovf <= bus.ovf;
      end else if (r_state == SHIFT) begin
         r_cnt <= r_cnt + 1'b1;
         r_mag <= r_mag << 1;
         r_bcd <= w_bcd_nxt;
         if (w_done) r_disp <= w_codes;
      end
   end

   always_comb begin
      w_idx_nxt = r_idx;
      if (r_scan_cnt == SCAN_LAST)
         w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
   end

   bcd_to_seven_seg u_seg (
      .i_code (r_disp[w_idx_nxt]),
      .o_seg  (w_seg)
   );

   // anode and seg are registered from the same next index so they change together
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
         r_anode    <= {{(DIGITS-1){1'b1}}, 1'b0};
         r_seg      <= SEG_BLANK;
      end else begin
         r_scan_cnt <= (r_scan_cnt == SCAN_LAST) ? '0 : r_scan_cnt + 1'b1;
         r_idx      <= w_idx_nxt;
         r_anode    <= ~(DIGITS'(1) << w_idx_nxt);
         r_seg      <= w_seg;
      end
   end

   assign bus.busy  = (r_state == SHIFT);
   assign bus.anode = r_anode;
   assign bus.seg   = r_seg;

endmodule

// File: tb/tb_sig_unsig_scan_display.sv
// Directed plus randomized checks of conversion timing, formatting, scanning and reset.
module tb_sig_unsig_scan_display;

   localparam int WIDTH    = 8;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sig_unsig_scan_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   sig_unsig_scan_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [DIGITS*7-1:0] cur_disp;
   logic [DIGITS*7-1:0] blank_disp;

   // Code 0-9 digits, 10 blank, 11 dash, 12 'E'; active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] pat(int code);
      case (code)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         11: return 7'b0111111;
         12: return 7'b0000110;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [DIGITS*7-1:0] model(int x, bit interp, bit ovf);
      logic [DIGITS*7-1:0] r;
      int v, nd, p;
      bit neg;
      for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = pat(10);
      if (ovf) begin
         r[6:0] = pat(12);
         return r;
      end
      neg = interp && (x >= 2**(WIDTH-1));
      v   = neg ? (2**WIDTH - x) : x;
      nd  = 1;
      p   = v;
      while (p >= 10) begin
         p  = p / 10;
         nd = nd + 1;
      end
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i < nd)                r[7*i +: 7] = pat((v / p) % 10);
         else if (neg && i == nd)   r[7*i +: 7] = pat(11);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full scan period; record the pattern shown for each lit digit
   task automatic read_disp(input string tag, output logic [DIGITS*7-1:0] d);
      int bad;
      bad = 0;
      d   = '1;
      for (int k = 0; k < DIGITS*SCAN_DIV; k++) begin
         tick();
         if ($countones(~bus.anode) != 1) bad++;
         for (int j = 0; j < DIGITS; j++)
            if (!bus.anode[j]) d[7*j +: 7] = bus.seg;
      end
      chk({tag, "_anode_onehot"}, bad, 0);
   endtask

   task automatic convert(input string tag, input logic [WIDTH-1:0] x, input bit interp,
                          input bit ovf, input bit second_load);
      int n, guard, stale;
      logic [DIGITS*7-1:0] obs, exp;
      bus.x      = x;
      bus.interp = interp;
      bus.ovf    = ovf;
      bus.load   = 1'b1;
      tick();
      bus.load = 1'b0;
      chk({tag, "_busy_rise"}, {31'd0, bus.busy}, 1);
      n = 0; guard = 0; stale = 0;
      while (bus.busy === 1'b1 && guard < 40) begin
         n++;
         for (int j = 0; j < DIGITS; j++)
            if (!bus.anode[j] && bus.seg !== cur_disp[7*j +: 7]) stale++;
         if (second_load && n == 3) begin
            bus.x      = ~x;
            bus.interp = ~interp;
            bus.ovf    = ~ovf;
            bus.load   = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
         tick();
         guard++;
      end
      bus.load = 1'b0;
      chk({tag, "_busy_cycles"}, n, WIDTH);
      chk({tag, "_old_display_held"}, stale, 0);
      exp = model(int'(x), interp, ovf);
      tick();
      read_disp(tag, obs);
      chk({tag, "_display"}, 32'(obs), 32'(exp));
      cur_disp = exp;
   endtask

   initial begin
      logic [DIGITS*7-1:0] obs;
      for (int i = 0; i < DIGITS; i++) blank_disp[7*i +: 7] = 7'b1111111;
      cur_disp   = blank_disp;
      bus.x      = '0;
      bus.interp = 1'b0;
      bus.ovf    = 1'b0;
      bus.load   = 1'b0;
      reset      = 1'b1;
      tick();
      tick();
      chk("reset_busy", {31'd0, bus.busy}, 0);
      chk("reset_anode", {28'd0, bus.anode}, 32'b1110);
      chk("reset_seg", {25'd0, bus.seg}, 32'h7F);
      reset = 1'b0;
      read_disp("reset", obs);
      chk("reset_display_blank", 32'(obs), 32'(blank_disp));

      convert("neg_fe",  8'hFE, 1'b1, 1'b0, 1'b0);
      convert("uns_fe",  8'hFE, 1'b0, 1'b0, 1'b0);
      convert("uns_0",   8'h00, 1'b0, 1'b0, 1'b0);
      convert("neg_80",  8'h80, 1'b1, 1'b0, 1'b0);
      convert("pos_7f",  8'h7F, 1'b1, 1'b0, 1'b0);
      convert("ovf_55",  8'h55, 1'b0, 1'b1, 1'b1);
      convert("neg_ff",  8'hFF, 1'b1, 1'b0, 1'b1);

      for (int r = 0; r < 12; r++)
         convert($sformatf("rand%0d", r), WIDTH'($urandom_range(0, 2**WIDTH - 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0));

      // Reset three cycles into a conversion
      bus.x = 8'h80; bus.interp = 1'b1; bus.ovf = 1'b0; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("midreset_busy", {31'd0, bus.busy}, 0);
      chk("midreset_seg", {25'd0, bus.seg}, 32'h7F);
      chk("scan_k0", {28'd0, bus.anode}, 32'b1110);
      reset = 1'b0;
      for (int k = 1; k <= DIGITS*SCAN_DIV; k++) begin
         logic [DIGITS-1:0] ea;
         tick();
         ea = ~(DIGITS'(1) << ((k / SCAN_DIV) % DIGITS));
         chk($sformatf("scan_k%0d", k), {28'd0, bus.anode}, {28'd0, ea});
      end
      cur_disp = blank_disp;
      read_disp("midreset", obs);
      chk("midreset_display_blank", 32'(obs), 32'(blank_disp));

      // Load coincident with reset must not start a conversion
      bus.x = 8'hFE; bus.interp = 1'b1; bus.load = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.load = 1'b0;
      tick();
      chk("load_with_reset_busy", {31'd0, bus.busy}, 0);
      read_disp("load_with_reset", obs);
      chk("load_with_reset_display", 32'(obs), 32'(blank_disp));

      convert("after_reset", 8'hFE, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sig_unsig_scan_display.md
SIG_UNSIG_SCAN_DISPLAY -- requirements
Module: sig_unsig_scan_display

Interface
REQ-001 Parameter WIDTH, 8: bit width of input value x.
REQ-002 Parameter DIGITS, 4: number of multiplexed seven-segment digits; SHALL satisfy DIGITS >= (decimal digits of 2^WIDTH - 1) + 1.
REQ-003 Parameter SCAN_DIV, 50000: clk cycles each digit is lit.
REQ-004 Port clk  in  1  rising-edge clock; one clock domain, and no other clock.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port x  in  WIDTH  value to display.
REQ-007 Port interp  in  1  1 = two's-complement signed; 0 = unsigned.
REQ-008 Port ovf  in  1  1 = display overflow indication instead of value.
REQ-009 Port load  in  1  single-cycle request to capture x/interp/ovf and convert.
REQ-010 Port busy  out  1  high while a conversion is in progress.
REQ-011 Port anode  out  DIGITS  active-low digit enables, one-hot-low; bit 0 = least significant digit.
REQ-012 Port seg  out  7  active-low segments {g,f,e,d,c,b,a} of the currently enabled digit.

Function
REQ-013 load sampled high while busy=0 SHALL capture x, interp, ovf; busy SHALL rise the next cycle.
REQ-014 load while busy=1 SHALL be ignored; captured operands SHALL not change.
REQ-015 Magnitude: if interp=1 and x[WIDTH-1]=1, magnitude = -x, computed in WIDTH+1 bits so that x = 2^(WIDTH-1) (most negative value) is correct; otherwise magnitude = x; negative flag = interp & x[WIDTH-1].
REQ-016 Binary-to-BCD SHALL be iterative shift-add-3 (double dabble), one magnitude bit per cycle, exactly WIDTH iterations.
REQ-017 busy SHALL stay high for exactly WIDTH cycles; on the cycle busy falls, the display register SHALL update atomically.
REQ-018 During a conversion the display SHALL continue to show the previous result unchanged.
REQ-019 Leading zeros SHALL be blanked (all segments off); value 0 SHALL show a single '0' in digit 0.
REQ-020 If negative, '-' (g only) SHALL appear in the digit immediately left of the most significant nonzero digit; all digits further left blank.
REQ-021 If captured ovf=1, digit 0 SHALL show 'E' and all other digits blank, regardless of x and interp; conversion timing unchanged.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0,1,...,DIGITS-1,0.
REQ-023 anode SHALL drive low only the bit of the current digit index; seg SHALL be that digit's pattern in the same cycle (registered outputs, no glitches between digits).
REQ-024 Scanning SHALL run continuously, independent of load/busy.

Reset
REQ-025 On reset: busy=0, conversion aborted, scan counter=0, digit index=0, anode = all ones except bit 0 low, seg = all ones (blank), display register all digits blank.
REQ-026 Reset asserted mid-conversion SHALL discard the conversion; a load in the same cycle as reset SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold seven-segment pattern constants (0-9, blank, dash, E) and the digit-code type (4-bit BCD plus blank/dash/E codes).
REQ-028 One sub-module bcd_to_seven_seg SHALL map a digit code to the active-low seg pattern; it SHALL be combinational and instantiated once, on the scanned digit.
REQ-029 Conversion FSM states: IDLE, SHIFT (WIDTH cycles, iteration counter), then back to IDLE; the display update SHALL occur on the SHIFT->IDLE transition.

Verification (WIDTH=8, DIGITS=4, SCAN_DIV=4)
REQ-030 interp=1, x=8'hFE, load -> busy high 8 cycles; then digits (3..0) = blank, blank, '-', '2'.
REQ-031 interp=0, x=8'hFE, load -> digits = blank, '2', '5', '4'; interp=0, x=0 -> blank, blank, blank, '0'.
REQ-032 interp=1, x=8'h80 -> '-', '1', '2', '8'; interp=1, x=8'h7F -> blank, '1', '2', '7'.
REQ-033 ovf=1, x=8'h55, load -> blank, blank, blank, 'E'; second load during busy ignored, result unchanged.
REQ-034 Reset 3 cycles into a conversion -> busy=0 next cycle, all digits blank; anode sequence after reset 1110,1101,1011,0111 each held 4 cycles, then wraps to 1110.
